spi_frame_slave: RTL and testbench

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_frame_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_frame_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave frame logic and the master-side logic.
package spi_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  function automatic int spi_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI line, with registered rise/fall detection.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign q_o = sync_q[STAGES-1];

  // Edges are masked until the chain has flushed its reset value, so a line
  // already away from its reset level at release does not look like an edge.
  assign rise_o = vld_q[STAGES] &  q_o & ~prev_q;
  assign fall_o = vld_q[STAGES] & ~q_o &  prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: synchronised sampling in the clk domain, multi-word frames, tx holding register.
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int                CNT_W    = spi_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (sclk),
    .q_o    (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (ss_n),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e state_q, state_d;
  logic       load_evt, shift_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ss_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_evt = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_LOAD:  load_evt = 1'b1;
      ST_SHIFT: shift_en = ~ss_rise;
      default:  ;
    endcase
  end

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  pend_q, pend_d;
  logic                  reload;

  always_comb begin
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    pend_d      = pend_q;

    // pend_q marks a completed word: its next sclk fall starts the next word.
    reload = load_evt | (shift_en & sclk_fall & pend_q);

    if (reload) begin
      tx_sr_d     = hold_full_q ? hold_q : '0;
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
      pend_d      = 1'b0;
    end else if (shift_en & sclk_fall) begin
      tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
    end

    if (shift_en & sclk_rise) begin
      rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        rx_data_d  = rx_sr_d;
        rx_valid_d = 1'b1;
        pend_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if ((state_q == ST_SHIFT) && ss_rise) begin
      cnt_d   = '0;
      pend_d  = 1'b0;
      abort_d = (cnt_q != '0);
    end

    // A new word accepted in the same cycle as a reload survives it.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      pend_q      <= pend_d;
    end
  end

  assign miso        = tx_sr_q[DATA_WIDTH-1];
  assign miso_oe     = ~ss_s;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: vector table of single-word frames plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_spi_frame_slave;

  logic        clk = 1'b0, reset = 1'b1;
  logic        sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [15:0] rx_data;

  always #5 clk = ~clk;

  spi_frame_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  typedef struct {
    logic        push;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] exp_rx;
    logic [15:0] exp_mi;
    int          exp_und;
  } vec_t;

  vec_t        vecs[5];
  int          checks = 0, errors = 0;
  int          n_rxv = 0, n_und = 0, n_abt = 0;
  logic        first = 1'b0;
  logic [15:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      rxq.push_back(rx_data);
    end
    if (tx_underrun) n_und++;
    if (frame_abort) n_abt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got tx_ready=%b expected 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic start_frame();
    ss_n  = 1'b0;
    first = 1'b1;
    wait_n(6);
  endtask

  // sclk half period is 4 clk cycles: sclk runs at exactly clk/8.
  task automatic xfer(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!first) sclk = 1'b0;
      first = 1'b0;
      mosi  = mo[15-b];
      wait_n(4);
      mi[15-b] = miso;
      sclk = 1'b1;
      wait_n(4);
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    wait_n(8);
    sclk = 1'b0;
    wait_n(8);
  endtask

  initial begin
    logic [15:0] mi, mi2, save, t, m;
    int rxv0, und0, abt0;

    vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 16'h1234, 16'hA5C3, 0};
    vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1};
    vecs[2] = '{1'b1, 16'h5A3C, 16'h0000, 16'h0000, 16'h5A3C, 0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 16'h8001, 16'hFFFF, 0};
    vecs[4] = '{1'b1, 16'h0001, 16'h7FFE, 16'h7FFE, 16'h0001, 0};

    wait_n(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0;
    wait_n(8);

    for (int i = 0; i < 5; i++) begin
      rxv0 = n_rxv; und0 = n_und; abt0 = n_abt;
      if (vecs[i].push) begin
        push(vecs[i].tx);
        chk($sformatf("v%0d_tx_ready_full", i), 32'(tx_ready), 32'd0);
      end
      start_frame();
      chk($sformatf("v%0d_tx_ready_load", i), 32'(tx_ready), 32'd1);
      chk($sformatf("v%0d_miso_oe", i), 32'(miso_oe), 32'd1);
      xfer(16, vecs[i].mo, mi);
      end_frame();
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_miso_word", i), 32'(mi), 32'(vecs[i].exp_mi));
      chk($sformatf("v%0d_rx_valid_cnt", i), 32'(n_rxv - rxv0), 32'd1);
      chk($sformatf("v%0d_underrun_cnt", i), 32'(n_und - und0), 32'(vecs[i].exp_und));
      chk($sformatf("v%0d_abort_cnt", i), 32'(n_abt - abt0), 32'd0);
    end

    // Two words in one frame, second reply queued after LOAD empties the holder.
    rxq.delete();
    rxv0 = n_rxv; und0 = n_und;
    push(16'h1111);
    start_frame();
    push(16'h2222);
    xfer(16, 16'h0001, mi);
    xfer(16, 16'h8000, mi2);
    end_frame();
    chk("two_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd2);
    chk("two_rx_q_len", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      chk("two_rx_word0", 32'(rxq[0]), 32'h0001);
      chk("two_rx_word1", 32'(rxq[1]), 32'h8000);
    end
    chk("two_miso_word0", 32'(mi), 32'h1111);
    chk("two_miso_word1", 32'(mi2), 32'h2222);
    chk("two_underrun_cnt", 32'(n_und - und0), 32'd0);

    // Abort after 7 bits, then a clean frame.
    save = rx_data;
    rxv0 = n_rxv; abt0 = n_abt;
    start_frame();
    xfer(7, 16'h5555, mi);
    end_frame();
    chk("abort_cnt", 32'(n_abt - abt0), 32'd1);
    chk("abort_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
    chk("abort_rx_data_kept", 32'(rx_data), 32'(save));
    rxv0 = n_rxv; abt0 = n_abt;
    push(16'h1357);
    start_frame();
    xfer(16, 16'hBEEF, mi);
    end_frame();
    chk("after_abort_rx_data", 32'(rx_data), 32'hBEEF);
    chk("after_abort_miso", 32'(mi), 32'h1357);
    chk("after_abort_rx_cnt", 32'(n_rxv - rxv0), 32'd1);
    chk("after_abort_abort_cnt", 32'(n_abt - abt0), 32'd0);

    // Reset mid-frame after 9 bits with ss_n held low; sclk ignored until ss_n toggles.
    push(16'hC0DE);
    start_frame();
    xfer(9, 16'hABCD, mi);
    rxv0 = n_rxv; und0 = n_und; abt0 = n_abt;
    reset = 1'b1;
    wait_n(2);
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_underrun", 32'(tx_underrun), 32'd0);
    chk("mid_rst_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0;
    wait_n(8);
    first = 1'b0;
    xfer(16, 16'hFFFF, mi);
    sclk = 1'b0;
    wait_n(8);
    chk("ign_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd0);
    chk("ign_underrun_cnt", 32'(n_und - und0), 32'd0);
    chk("ign_abort_cnt", 32'(n_abt - abt0), 32'd0);
    chk("ign_rx_data", 32'(rx_data), 32'h0);
    ss_n = 1'b1;
    wait_n(8);
    chk("ign_end_abort_cnt", 32'(n_abt - abt0), 32'd0);
    push(16'h3C3C);
    start_frame();
    xfer(16, 16'h0F0F, mi);
    end_frame();
    chk("post_rst_rx_data", 32'(rx_data), 32'h0F0F);
    chk("post_rst_miso", 32'(mi), 32'h3C3C);
    chk("post_rst_rx_cnt", 32'(n_rxv - rxv0), 32'd1);

    // Random frames at clk/8.
    for (int f = 0; f < 100; f++) begin
      t = 16'($urandom);
      m = 16'($urandom);
      rxv0 = n_rxv;
      push(t);
      start_frame();
      xfer(16, m, mi);
      end_frame();
      chk($sformatf("rnd%0d_rx", f), 32'(rx_data), 32'(m));
      chk($sformatf("rnd%0d_miso", f), 32'(mi), 32'(t));
      chk($sformatf("rnd%0d_rx_cnt", f), 32'(n_rxv - rxv0), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
